// File: rtl/cpu_bus_responder_if.sv
// cpu_bus_responder_if: CPU-side memory bus between the initiators and the bus responder.
// Latency: none (wires only); the responder registers read data one cycle after the address.
// Backpressure: none; the responder stalls initiators only through cpu_halt.
interface cpu_bus_responder_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic        cpu_halt;

  modport master (
    output cpu_addr, cpu_wdata, cpu_write_en, cpu_read_en,
    input  cpu_rdata, cpu_halt
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write_en, cpu_read_en,
    output cpu_rdata, cpu_halt
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU address decode (RAM/PPU/IO/PRG), registered read mux, write/side-effect strobes.
// Latency: cpu_rdata valid 1 cycle after the address; device strobes are combinational in the same cycle.
// Backpressure: none on the bus; with CPU_OAM_DMA_EN a $4014 write holds cpu_halt for 514 cycles.
module cpu_bus_responder #(
  parameter int unsigned RAM_AW   = 11,
  parameter logic [15:0] DMA_TRIG = 16'h4014,
  parameter logic [2:0]  OAM_REG  = 3'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_bus_responder_if.slave   bus,
  output logic [2:0]           ppu_reg_addr,
  output logic [7:0]           ppu_reg_wdata,
  input  logic [7:0]           ppu_reg_rdata,
  output logic                 ppu_reg_we,
  output logic                 ppu_reg_re,
  output logic [4:0]           io_addr,
  output logic [7:0]           io_wdata,
  input  logic [7:0]           io_rdata,
  output logic                 io_we,
  output logic                 io_re,
  output logic [14:0]          prg_addr,
  output logic [7:0]           prg_wdata,
  input  logic [7:0]           prg_rdata,
  output logic                 prg_we
);

  logic [7:0]  ram [0:(1<<RAM_AW)-1];
  logic [15:0] bus_addr;     // CPU address, or the DMA read address while halted
  logic        halt_q;
  logic [7:0]  rdata_q;
  logic        dma_wr;       // DMA is presenting a byte to OAMDATA this cycle
  logic [7:0]  dma_data;
  logic        trig_hit;
  logic        bus_ok;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        ram_hit, ppu_hit, io_hit, prg_hit, open_hit;
  logic [7:0]  rd_mux;

  assign ram_hit  = (bus_addr[15:13] == 3'b000);
  assign ppu_hit  = (bus_addr[15:13] == 3'b001);
  assign io_hit   = (bus_addr[15:5] == 11'h200);
  assign prg_hit  = bus_addr[15];
  assign open_hit = ~(ram_hit | ppu_hit | io_hit | prg_hit);
  assign trig_hit = (bus.cpu_addr == DMA_TRIG);

  // CPU requests only count outside reset and outside a DMA; a write masks the read strobe.
  assign bus_ok = rst & ~halt_q;
  assign cpu_wr = bus.cpu_write_en & bus_ok;
  assign cpu_rd = bus.cpu_read_en & ~bus.cpu_write_en & bus_ok;

`ifdef CPU_OAM_DMA_EN
  localparam bit DMA_BUILT = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_RD, S_WR, S_DONE} dma_state_t;

  dma_state_t state;
  logic [7:0] page;
  logic [7:0] idx;

  assign bus_addr = halt_q ? {page, idx} : bus.cpu_addr;
  assign dma_wr   = (state == S_WR);

  // OAM DMA sequencer: halt from the cycle after the trigger, 256 read/write pairs, one trailing cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      dma_data <= 8'h00;
      halt_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_wr && trig_hit) begin
            page   <= bus.cpu_wdata;
            idx    <= 8'h00;
            halt_q <= 1'b1;
            state  <= S_ALIGN;
          end
        end
        S_ALIGN: state <= S_RD;
        S_RD: begin
          // Open-bus pages keep the previously fetched byte.
          if (!open_hit) dma_data <= rd_mux;
          state <= S_WR;
        end
        S_WR: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? S_DONE : S_RD;
        end
        S_DONE: begin
          idx    <= 8'h00;
          halt_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          halt_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end
`else
  localparam bit DMA_BUILT = 1'b0;

  assign bus_addr = bus.cpu_addr;
  assign halt_q   = 1'b0;
  assign dma_wr   = 1'b0;
  assign dma_data = 8'h00;
`endif

  // Read source select for the current bus address (CPU or DMA).
  always_comb begin
    rd_mux = 8'h00;
    if (ram_hit)      rd_mux = ram[bus_addr[RAM_AW-1:0]];
    else if (ppu_hit) rd_mux = ppu_reg_rdata;
    else if (io_hit)  rd_mux = io_rdata;
    else if (prg_hit) rd_mux = prg_rdata;
  end

  // Internal RAM, mirrored across $0000-$1FFF; contents survive reset.
  always_ff @(posedge clk) begin
    if (cpu_wr && ram_hit) ram[bus_addr[RAM_AW-1:0]] <= bus.cpu_wdata;
  end

  // Registered read data; open bus and DMA cycles leave the last value in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        rdata_q <= 8'h00;
    else if (!halt_q && !open_hit)   rdata_q <= rd_mux;
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_halt  = halt_q;

  // Device strobes; the DMA write phase takes over the PPU port.
  always_comb begin
    ppu_reg_addr  = bus_addr[2:0];
    ppu_reg_wdata = bus.cpu_wdata;
    ppu_reg_we    = cpu_wr & ppu_hit;
    ppu_reg_re    = cpu_rd & ppu_hit;
    if (dma_wr) begin
      ppu_reg_addr  = OAM_REG;
      ppu_reg_wdata = dma_data;
      ppu_reg_we    = 1'b1;
    end
    io_addr   = bus_addr[4:0];
    io_wdata  = bus.cpu_wdata;
    io_we     = cpu_wr & io_hit & ~(DMA_BUILT & trig_hit);
    io_re     = cpu_rd & io_hit;
    prg_addr  = bus_addr[14:0];
    prg_wdata = bus.cpu_wdata;
    prg_we    = cpu_wr & prg_hit;
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
`timescale 1ns/1ps
module tb_cpu_bus_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_reg_wdata, ppu_reg_rdata;
  logic        ppu_reg_we, ppu_reg_re;
  logic [4:0]  io_addr;
  logic [7:0]  io_wdata, io_rdata;
  logic        io_we, io_re;
  logic [14:0] prg_addr;
  logic [7:0]  prg_wdata, prg_rdata;
  logic        prg_we;

  cpu_bus_responder_if bus();

  cpu_bus_responder dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ppu_reg_addr(ppu_reg_addr), .ppu_reg_wdata(ppu_reg_wdata), .ppu_reg_rdata(ppu_reg_rdata),
    .ppu_reg_we(ppu_reg_we), .ppu_reg_re(ppu_reg_re),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata), .io_we(io_we), .io_re(io_re),
    .prg_addr(prg_addr), .prg_wdata(prg_wdata), .prg_rdata(prg_rdata), .prg_we(prg_we)
  );

  int checks = 0;
  int errors = 0;

  // Device models: PPU register file and fixed IO/PRG patterns.
  logic [7:0] ppu_regs [0:7];
  function automatic logic [7:0] io_val(input logic [4:0] o);
    return {o, o[2:0]} ^ 8'hC3;
  endfunction
  function automatic logic [7:0] prg_val(input logic [14:0] o);
    return o[7:0] ^ {o[14:8], 1'b0} ^ 8'h5A;
  endfunction
  assign ppu_reg_rdata = ppu_regs[ppu_reg_addr];
  assign io_rdata      = io_val(io_addr);
  assign prg_rdata     = prg_val(prg_addr);

  // Reference model state.
  logic [7:0] ram_m [0:2047];
  logic [7:0] rdata_m;
  logic [8:0] pend_r;
  logic       pend_wr_ram;
  logic [15:0] pend_a;
  logic [7:0] pend_d;

  // Returns {has_data, data} as the memory map defines it.
  function automatic logic [8:0] model_read(input logic [15:0] a);
    logic [15:0] off;
    if (a < 16'h2000) return {1'b1, ram_m[a % 16'd2048]};
    if (a < 16'h4000) return {1'b1, ppu_regs[a % 16'd8]};
    if (a < 16'h4020) begin off = a - 16'h4000; return {1'b1, io_val(off[4:0])}; end
    if (a < 16'h8000) return {1'b0, 8'h00};
    off = a - 16'h8000;
    return {1'b1, prg_val(off[14:0])};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic set_bus(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_write_en = we; bus.cpu_read_en = re;
  endtask

  // Present a request and stop at the following negedge, model update pending.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we, input logic re);
    set_bus(a, d, we, re);
    pend_r = model_read(a);
    pend_wr_ram = we && (a < 16'h2000);
    pend_a = a % 16'd2048;
    pend_d = d;
    @(negedge clk);
  endtask

  task automatic commit();
    @(posedge clk); #1;
    if (pend_r[8]) rdata_m = pend_r[7:0];
    if (pend_wr_ram) ram_m[pend_a] = pend_d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_bus(16'h2003, 8'h77, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", bus.cpu_rdata); end
    checks++; if (bus.cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", bus.cpu_halt); end
    checks++; if ({ppu_reg_we, ppu_reg_re, io_we, io_re, prg_we} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {ppu_reg_we, ppu_reg_re, io_we, io_re, prg_we}); end
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    rdata_m = 8'h00;
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 2048; i++) begin
      logic [15:0] a;
      a = 16'(i) + 16'(2048 * $urandom_range(0, 3));
      drive(a, 8'($urandom), 1'b1, 1'b0);
      commit();
    end
    drive(16'h0000, 8'h00, 1'b0, 1'b0);
    commit();
    checks++; if (bus.cpu_rdata !== rdata_m) begin errors++; $display("FAIL fill_readback got %h want %h", bus.cpu_rdata, rdata_m); end
  endtask

  task automatic test_ram_mirror();
    drive(16'h0005, 8'hA5, 1'b1, 1'b0); commit();
    drive(16'h0805, 8'h00, 1'b0, 1'b0); commit();
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL mirror_0805 got %h want a5", bus.cpu_rdata); end
    drive(16'h1805, 8'h00, 1'b0, 1'b0); commit();
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL mirror_1805 got %h want a5", bus.cpu_rdata); end
  endtask

  task automatic test_ppu();
    drive(16'h3FFA, 8'h12, 1'b1, 1'b0);
    checks++; if ({ppu_reg_addr, ppu_reg_wdata, ppu_reg_we, ppu_reg_re} !== {3'd2, 8'h12, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ppu_write got addr=%0d data=%h we=%b re=%b want addr=2 data=12 we=1 re=0",
                         ppu_reg_addr, ppu_reg_wdata, ppu_reg_we, ppu_reg_re); end
    commit();
    drive(16'h0000, 8'h00, 1'b0, 1'b0);
    checks++; if (ppu_reg_we !== 1'b0) begin errors++; $display("FAIL ppu_we_one_cycle got %b want 0", ppu_reg_we); end
    commit();
    drive(16'h2002, 8'h00, 1'b0, 1'b1);
    checks++; if (ppu_reg_re !== 1'b1 || ppu_reg_addr !== 3'd2) begin
      errors++; $display("FAIL ppu_read_en got re=%b addr=%0d want re=1 addr=2", ppu_reg_re, ppu_reg_addr); end
    commit();
    checks++; if (bus.cpu_rdata !== ppu_regs[2]) begin errors++; $display("FAIL ppu_rdata got %h want %h", bus.cpu_rdata, ppu_regs[2]); end
    drive(16'h2002, 8'h00, 1'b0, 1'b0);
    checks++; if (ppu_reg_re !== 1'b0) begin errors++; $display("FAIL ppu_no_read_en got re=%b want 0", ppu_reg_re); end
    commit();
    checks++; if (bus.cpu_rdata !== ppu_regs[2]) begin errors++; $display("FAIL ppu_rdata_no_re got %h want %h", bus.cpu_rdata, ppu_regs[2]); end
    drive(16'h2002, 8'h55, 1'b1, 1'b1);
    checks++; if (ppu_reg_re !== 1'b0 || ppu_reg_we !== 1'b1) begin
      errors++; $display("FAIL ppu_write_wins got re=%b we=%b want re=0 we=1", ppu_reg_re, ppu_reg_we); end
    commit();
  endtask

  task automatic test_back_to_back();
    logic [7:0] x, y;
    x = 8'($urandom); y = ~x;
    drive(16'h01FE, x, 1'b1, 1'b0); commit();
    drive(16'h01FF, y, 1'b1, 1'b0); commit();
    drive(16'h01FE, 8'h00, 1'b0, 1'b0); commit();
    checks++; if (bus.cpu_rdata !== x) begin errors++; $display("FAIL b2b_01fe got %h want %h", bus.cpu_rdata, x); end
    drive(16'h01FF, 8'h00, 1'b0, 1'b0); commit();
    checks++; if (bus.cpu_rdata !== y) begin errors++; $display("FAIL b2b_01ff got %h want %h", bus.cpu_rdata, y); end
  endtask

  task automatic test_open_bus();
    drive(16'h0005, 8'h00, 1'b0, 1'b1); commit();
    drive(16'h5000, 8'h00, 1'b0, 1'b1); commit();
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL open_5000 got %h want a5", bus.cpu_rdata); end
    drive(16'h4020, 8'h00, 1'b0, 1'b1); commit();
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL open_4020 got %h want a5", bus.cpu_rdata); end
    drive(16'h7FFF, 8'h99, 1'b1, 1'b0);
    checks++; if ({ppu_reg_we, io_we, prg_we} !== 3'b000) begin
      errors++; $display("FAIL open_write_strobes got %b want 000", {ppu_reg_we, io_we, prg_we}); end
    commit();
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL open_7fff got %h want a5", bus.cpu_rdata); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      logic [15:0] a;
      logic [7:0]  d;
      logic        we, re, in_ppu, in_io, in_prg, ok;
      logic [4:0]  exp_s, got_s;
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom_range(16'h0000, 16'h1FFF));
        1:       a = 16'($urandom_range(16'h2000, 16'h3FFF));
        2:       a = 16'($urandom_range(16'h4000, 16'h401F));
        3:       a = 16'($urandom_range(16'h4020, 16'h7FFF));
        default: a = 16'($urandom_range(16'h8000, 16'hFFFF));
      endcase
`ifdef CPU_OAM_DMA_EN
      if (a == 16'h4014) a = 16'h4015;
`endif
      d  = 8'($urandom);
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 1) == 1);
      in_ppu = (a >= 16'h2000) && (a < 16'h4000);
      in_io  = (a >= 16'h4000) && (a < 16'h4020);
      in_prg = (a >= 16'h8000);
      drive(a, d, we, re);
      exp_s = {we && in_ppu, re && !we && in_ppu, we && in_io, re && !we && in_io, we && in_prg};
      got_s = {ppu_reg_we, ppu_reg_re, io_we, io_re, prg_we};
      checks++; if (got_s !== exp_s) begin
        errors++; $display("FAIL rand_strobes addr=%h got %b want %b", a, got_s, exp_s); end
      ok = 1'b1;
      if (in_ppu && (ppu_reg_addr !== 3'(a % 16'd8) || (we && ppu_reg_wdata !== d))) ok = 1'b0;
      if (in_io  && (io_addr !== 5'(a - 16'h4000) || (we && io_wdata !== d))) ok = 1'b0;
      if (in_prg && (prg_addr !== 15'(a - 16'h8000) || (we && prg_wdata !== d))) ok = 1'b0;
      checks++; if (!ok) begin
        errors++; $display("FAIL rand_dev_addr addr=%h got ppu=%0d io=%h prg=%h want offsets of %h", a, ppu_reg_addr, io_addr, prg_addr, a); end
      commit();
      checks++; if (bus.cpu_rdata !== rdata_m) begin
        errors++; $display("FAIL rand_rdata addr=%h got %h want %h", a, bus.cpu_rdata, rdata_m); end
    end
  endtask

`ifdef CPU_OAM_DMA_EN
  // Trigger one DMA from the given page and check halt length, OAM byte stream and CPU isolation.
  task automatic run_dma(input logic [7:0] page);
    int hcnt, n, bad, cyc;
    logic [8:0] r;
    drive(16'h4014, page, 1'b1, 1'b0);
    checks++; if (io_we !== 1'b0) begin errors++; $display("FAIL dma_trig_io_we got %b want 0", io_we); end
    commit();
    set_bus(16'h0000, 8'hEE, 1'b1, 1'b1);
    hcnt = 0; n = 0; bad = 0; cyc = 0;
    while (cyc < 700) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_halt !== 1'b1) break;
      hcnt++;
      if (io_we || io_re || prg_we || ppu_reg_re) bad++;
      if (bus.cpu_rdata !== rdata_m) bad++;
      if (ppu_reg_we) begin
        r = model_read({page, 8'(n)});
        if (ppu_reg_addr !== 3'd4 || ppu_reg_wdata !== r[7:0]) begin
          if (bad == 0) $display("FAIL dma_byte idx=%0d got addr=%0d data=%h want addr=4 data=%h", n, ppu_reg_addr, ppu_reg_wdata, r[7:0]);
          bad++;
        end
        n++;
      end
    end
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    rdata_m = ram_m[0];
    checks++; if (hcnt != 514) begin errors++; $display("FAIL dma_halt_len page=%h got %0d want 514", page, hcnt); end
    checks++; if (n != 256) begin errors++; $display("FAIL dma_pulses page=%h got %0d want 256", page, n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL dma_stream page=%h got %0d bad cycles want 0", page, bad); end
    checks++; if (bus.cpu_rdata !== rdata_m) begin
      errors++; $display("FAIL dma_ram0_intact got %h want %h", bus.cpu_rdata, rdata_m); end
  endtask

  task automatic test_dma();
    for (int i = 0; i < 256; i++) begin
      drive(16'h0200 + 16'(i), 8'(i), 1'b1, 1'b0);
      commit();
    end
    run_dma(8'h02);
    run_dma(8'h21);
    run_dma(8'h9C);
  endtask

  task automatic test_reset_mid_dma();
    int n, cyc;
    drive(16'h4014, 8'h02, 1'b1, 1'b0); commit();
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    n = 0; cyc = 0;
    while (n < 80 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ppu_reg_we) n++;
    end
    checks++; if (n != 80) begin errors++; $display("FAIL mid_dma_reach got %0d pulses want 80", n); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.cpu_halt !== 1'b0 || ppu_reg_we !== 1'b0 || bus.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL mid_dma_reset got halt=%b we=%b rdata=%h want 0 0 00", bus.cpu_halt, ppu_reg_we, bus.cpu_rdata); end
    rdata_m = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    run_dma(8'h02);
  endtask
`else
  task automatic test_trig_plain_io();
    drive(16'h4014, 8'h03, 1'b1, 1'b0);
    checks++; if ({io_we, io_addr, io_wdata, bus.cpu_halt} !== {1'b1, 5'h14, 8'h03, 1'b0}) begin
      errors++; $display("FAIL trig_plain_io got we=%b addr=%h data=%h halt=%b want 1 14 03 0", io_we, io_addr, io_wdata, bus.cpu_halt); end
    commit();
    checks++; if (bus.cpu_halt !== 1'b0) begin errors++; $display("FAIL trig_no_halt got %b want 0", bus.cpu_halt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) ppu_regs[i] = 8'($urandom);
    set_bus(16'h0000, 8'h00, 1'b0, 1'b0);
    test_reset();
    fill_ram();
    test_ram_mirror();
    test_ppu();
    test_back_to_back();
    test_open_bus();
    test_random();
`ifdef CPU_OAM_DMA_EN
    test_dma();
    test_reset_mid_dma();
`else
    test_trig_plain_io();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
